omsp_spm_key_latch: RTL and testbench

Captures the 128-bit key derived by the HMAC control's HKDF flow, one 16-bit word per `write_key` pulse, into a staging buffer. After the last word arrives it commits the staged key atomically to a key register that the HMAC core and SPM key logic read. It sits directly downstream of the HMAC control's key-output path (`write_key` / `data_out`). A partial capture is discarded when the controller aborts via `hmac_reset`.

---
 rtl/omsp_spm_key_latch.sv | 156 +++++++++++++++
 tb/tb_omsp_spm_key_latch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/omsp_spm_key_latch.sv
// rtl/omsp_spm_key_latch.sv - stages HKDF key words and commits the full key atomically
// Optional feature: define SPM_KEY_ZEROIZE_EN to scrub key material on abort/clear and mask reads.
module omsp_spm_key_latch #(
    parameter int KEY_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hmac_reset_i,
    input  logic                    write_key_i,
    input  logic [15:0]             key_word_in_i,
    input  logic                    key_clear_i,
    input  logic [2:0]              key_rd_idx_i,
    output logic [16*KEY_WORDS-1:0] key_out_o,
    output logic [15:0]             key_rd_data_o,
    output logic                    key_valid_o,
    output logic                    capturing_o,
    output logic                    key_commit_o,
    output logic                    key_abort_o
);
    localparam int CW = $clog2(KEY_WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(KEY_WORDS - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [15:0]             stage_q [KEY_WORDS];
    logic [15:0]             stage_d [KEY_WORDS];
    logic [16*KEY_WORDS-1:0] key_q, key_d;
    logic                    key_valid_q, key_valid_d;
    logic                    commit_q, abort_q;
    logic                    accept, last_word, abort;

    // hmac_reset outranks write_key, so a strobe during abort/idle is never staged
    assign accept    = write_key_i && !hmac_reset_i;
    assign abort     = hmac_reset_i && (state_q == FILL);
    assign last_word = accept && (wcnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = (key_valid_q && !key_clear_i) ? HOLD : EMPTY;
        end else if (last_word) begin
            state_d = HOLD;
        end else if (accept) begin
            state_d = FILL;
        end else if (state_q != FILL && key_clear_i) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        capturing_o  = (state_q == FILL);
        key_valid_o  = key_valid_q;
        key_commit_o = commit_q;
        key_abort_o  = abort_q;
        key_out_o    = key_q;
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (abort || last_word) begin
            wcnt_d = '0;
        end else if (accept) begin
            wcnt_d = wcnt_q + CW'(1);
        end
    end

    // Word n of the key (MSW first) lands in stage[KEY_WORDS-1-n]
    always_comb begin
        for (int i = 0; i < KEY_WORDS; i++) begin
            stage_d[i] = stage_q[i];
`ifdef SPM_KEY_ZEROIZE_EN
            if (abort || (key_clear_i && !accept)) begin
                stage_d[i] = '0;
            end
`endif
            if (accept && (i == KEY_WORDS - 1 - int'(wcnt_q))) begin
                stage_d[i] = key_word_in_i;
            end
        end
    end

    always_comb begin
        key_d = key_q;
        if (last_word) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                key_d[16*i +: 16] = (i == 0) ? key_word_in_i : stage_q[i];
            end
        end
`ifdef SPM_KEY_ZEROIZE_EN
        else if (key_clear_i) begin
            key_d = '0;
        end
`endif
    end

    // A commit in the same cycle as a clear wins
    always_comb begin
        key_valid_d = key_valid_q;
        if (last_word) begin
            key_valid_d = 1'b1;
        end else if (key_clear_i) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            abort_q     <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            wcnt_q      <= wcnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            commit_q    <= last_word;
            abort_q     <= abort;
            for (int i = 0; i < KEY_WORDS; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        key_rd_data_o = '0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (int'(key_rd_idx_i) == i) begin
                key_rd_data_o = key_q[16*(KEY_WORDS-1-i) +: 16];
            end
        end
`ifdef SPM_KEY_ZEROIZE_EN
        if (!key_valid_q) begin
            key_rd_data_o = '0;
        end
`endif
    end

endmodule

// File: tb/tb_omsp_spm_key_latch.sv
// tb/tb_omsp_spm_key_latch.sv - self-checking bench for omsp_spm_key_latch
// Reference model keeps staged words in a queue and forms the key by concatenation.
module tb_omsp_spm_key_latch;
    localparam int KW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           hmac_reset;
    logic           write_key;
    logic [15:0]    key_word_in;
    logic           key_clear;
    logic [2:0]     key_rd_idx;
    logic [16*KW-1:0] key_out;
    logic [15:0]    key_rd_data;
    logic           key_valid;
    logic           capturing;
    logic           key_commit;
    logic           key_abort;

    int ncmp = 0;
    int nfail = 0;

    logic [15:0]     q_m [$];
    logic [16*KW-1:0] key_m;
    bit              valid_m;
    logic [16*KW-1:0] key_a;

    omsp_spm_key_latch #(.KEY_WORDS(KW)) dut (
        .clk          (clk),
        .reset        (reset),
        .hmac_reset_i (hmac_reset),
        .write_key_i  (write_key),
        .key_word_in_i(key_word_in),
        .key_clear_i  (key_clear),
        .key_rd_idx_i (key_rd_idx),
        .key_out_o    (key_out),
        .key_rd_data_o(key_rd_data),
        .key_valid_o  (key_valid),
        .capturing_o  (capturing),
        .key_commit_o (key_commit),
        .key_abort_o  (key_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] idx);
        logic [15:0] r;
        r = 16'(key_m >> (16 * (KW - 1 - int'(idx))));
`ifdef SPM_KEY_ZEROIZE_EN
        if (!valid_m) r = '0;
`endif
        return r;
    endfunction

    task automatic check_all(input bit commit, input bit abort);
        chk("key_out", key_out, key_m);
        chk("key_valid", key_valid, valid_m);
        chk("capturing", capturing, q_m.size() != 0);
        chk("key_commit", key_commit, commit);
        chk("key_abort", key_abort, abort);
        chk("key_rd_data", key_rd_data, exp_rd(key_rd_idx));
    endtask

    task automatic model_reset();
        q_m.delete();
        key_m   = '0;
        valid_m = 1'b0;
    endtask

    task automatic step(input bit hr, input bit wk, input logic [15:0] w, input bit clr);
        bit accept, abort, commit;
        @(negedge clk);
        hmac_reset  = hr;
        write_key   = wk;
        key_word_in = w;
        key_clear   = clr;
        key_rd_idx  = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        accept = wk && !hr;
        abort  = hr && (q_m.size() != 0);
        commit = 1'b0;
        if (abort) begin
            q_m.delete();
        end else if (accept) begin
            q_m.push_back(w);
            if (q_m.size() == KW) begin
                key_m = '0;
                foreach (q_m[i]) key_m = {key_m[16*KW-17:0], q_m[i]};
                valid_m = 1'b1;
                commit  = 1'b1;
                q_m.delete();
            end
        end
        if (clr && !commit) begin
            valid_m = 1'b0;
`ifdef SPM_KEY_ZEROIZE_EN
            key_m = '0;
            if (!accept) foreach (q_m[i]) q_m[i] = '0;
`endif
        end
        check_all(commit, abort);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] w);
        step(1'b0, 1'b1, w, 1'b0);
        idle();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        hmac_reset = 1'b0;
        write_key = 1'b0;
        key_word_in = '0;
        key_clear = 1'b0;
        key_rd_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // full capture, strobes 3 cycles apart
        for (int k = 1; k <= 8; k++) wr(16'(k));
        chk("full_key_const", key_out, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

        // abort after a partial capture, then a fresh key
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 5; k++) wr(16'($urandom));
        step(1'b1, 1'b0, 16'h0, 1'b0);
        idle();
        for (int k = 0; k < 8; k++) wr(16'hAAAA);
        chk("aaaa_key_const", key_out, {8{16'hAAAA}});

        // re-key: old key stays visible until the 8th word
        key_a = key_m;
        for (int k = 0; k < 4; k++) wr(16'($urandom));
        chk("no_tear", key_out, key_a);
        chk("no_tear_valid", key_valid, 1'b1);
        for (int k = 0; k < 4; k++) wr(16'($urandom));

        // hmac_reset together with write_key during FILL
        for (int k = 0; k < 3; k++) wr(16'($urandom));
        step(1'b1, 1'b1, 16'hDEAD, 1'b0);
        for (int k = 0; k < 8; k++) wr(16'($urandom));

        // key_clear together with the 8th strobe
        for (int k = 0; k < 7; k++) wr(16'($urandom));
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("clear_vs_commit", key_valid, 1'b1);

        // clear, then read every word index
        step(1'b1, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < KW; i++) begin
            key_rd_idx = 3'(i);
            #1;
            chk("rd_after_clear", key_rd_data, exp_rd(3'(i)));
        end

        // back-to-back strobes
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'($urandom), 1'b0);

        // asynchronous reset mid-capture
        for (int k = 0; k < 3; k++) wr(16'($urandom));
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end
endmodule
